debounce_scan_ctrl: RTL and testbench

DEBOUNCE_SCAN_CTRL -- requirements
Module: debounce_scan_ctrl

---
 rtl/debounce_scan_ctrl.sv | 126 ++++++++++++
 tb/tb_debounce_scan_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_scan_ctrl.sv
// Multi-channel debouncer with one shared compare/increment datapath.
// Services one channel per cycle, round-robin, while scanning.
module debounce_scan_ctrl #(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         noisy_in,
    input  logic [CNT_W-1:0]          threshold,
    input  logic                      enable,
    input  logic                      clear,
    output logic [NUM_CH-1:0]         clean_out,
    output logic                      edge_valid,
    output logic [$clog2(NUM_CH)-1:0] edge_ch,
    output logic                      edge_dir,
    output logic [$clog2(NUM_CH)-1:0] scan_idx
);

    localparam int              IW      = $clog2(NUM_CH);
    localparam logic [IW-1:0]   LAST    = IW'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [NUM_CH-1:0] sync1_q, sync2_q;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d;
    logic [NUM_CH-1:0] clean_q, clean_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              ev_q, ev_d;
    logic [IW-1:0]     ech_q, ech_d;
    logic              dir_q, dir_d;

    logic              service;
    logic [CNT_W-1:0]  eff_thr;
    logic [CNT_W-1:0]  cur_cnt;
    logic [CNT_W:0]    inc;
    logic              cur_in;
    logic              cur_out;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = SCAN;
            SCAN:    if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear) state_d = IDLE;
    end

    always_comb begin
        service = (state_q == SCAN) && enable && !clear;
        eff_thr = (threshold == '0) ? CNT_W'(1) : threshold;
        cur_cnt = cnt_q[idx_q];
        cur_in  = sync2_q[idx_q];
        cur_out = clean_q[idx_q];
        inc     = {1'b0, cur_cnt} + {{CNT_W{1'b0}}, 1'b1};
        cnt_d   = cur_cnt;
        clean_d = clean_q;
        idx_d   = idx_q;
        ev_d    = 1'b0;
        ech_d   = ech_q;
        dir_d   = dir_q;
        if (clear) begin
            idx_d = '0;
        end else if (service) begin
            idx_d = (idx_q == LAST) ? '0 : idx_q + 1'b1;
            if (cur_in == cur_out) begin
                cnt_d = '0;
            end else if (inc >= {1'b0, eff_thr}) begin
                clean_d[idx_q] = cur_in;
                cnt_d          = '0;
                ev_d           = 1'b1;
                ech_d          = idx_q;
                dir_d          = cur_in;
            end else begin
                // Hold at full scale rather than wrap to zero
                cnt_d = (cur_cnt == CNT_MAX) ? CNT_MAX : inc[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sync1_q <= '0;
            sync2_q <= '0;
            clean_q <= '0;
            idx_q   <= '0;
            ev_q    <= 1'b0;
            ech_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= noisy_in;
            sync2_q <= sync1_q;
            clean_q <= clean_d;
            idx_q   <= idx_d;
            ev_q    <= ev_d;
            ech_q   <= ech_d;
            dir_q   <= dir_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
        end else if (service) begin
            cnt_q[idx_q] <= cnt_d;
        end
    end

    assign clean_out  = clean_q;
    assign edge_valid = ev_q;
    assign edge_ch    = ech_q;
    assign edge_dir   = dir_q;
    assign scan_idx   = idx_q;

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Directed plus randomized bench for debounce_scan_ctrl (4 channels)
// against a cycle-level behavioural model of the debounce rules.
module tb_debounce_scan_ctrl;

    localparam int NCH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] noisy_in;
    logic [7:0] threshold;
    logic       enable;
    logic       clear;
    logic [3:0] clean_out;
    logic       edge_valid;
    logic [1:0] edge_ch;
    logic       edge_dir;
    logic [1:0] scan_idx;

    int total = 0;
    int bad   = 0;
    int n_edges = 0;

    // Reference model state
    logic [3:0] m_s1, m_s2, m_clean;
    int         m_cnt [NCH];
    int         m_idx;
    bit         m_scan;
    bit         m_ev;
    int         m_ech;
    bit         m_dir;

    debounce_scan_ctrl #(.NUM_CH(4), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .noisy_in   (noisy_in),
        .threshold  (threshold),
        .enable     (enable),
        .clear      (clear),
        .clean_out  (clean_out),
        .edge_valid (edge_valid),
        .edge_ch    (edge_ch),
        .edge_dir   (edge_dir),
        .scan_idx   (scan_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_clean = '0;
        for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
        m_idx = 0; m_scan = 0; m_ev = 0; m_ech = 0; m_dir = 0;
    endtask

    // Advance the model across one rising edge using the current inputs
    task automatic model_edge();
        int thr;
        int c;
        m_ev = 0;
        if (clear) begin
            for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
            m_idx  = 0;
            m_scan = 0;
        end else begin
            if (m_scan && enable) begin
                c   = m_idx;
                thr = (threshold == 0) ? 1 : int'(threshold);
                if (m_s2[c] == m_clean[c]) begin
                    m_cnt[c] = 0;
                end else if (m_cnt[c] + 1 >= thr) begin
                    m_clean[c] = m_s2[c];
                    m_cnt[c]   = 0;
                    m_ev  = 1;
                    m_ech = c;
                    m_dir = m_s2[c];
                end else begin
                    m_cnt[c] = (m_cnt[c] >= 255) ? 255 : m_cnt[c] + 1;
                end
                m_idx = (m_idx + 1) % NCH;
            end
            m_scan = enable;
        end
        m_s2 = m_s1;
        m_s1 = noisy_in;
    endtask

    task automatic check_all();
        chk("clean_out", clean_out, m_clean);
        chk("edge_valid", edge_valid, m_ev);
        chk("scan_idx", scan_idx, m_idx);
        if (m_ev) begin
            chk("edge_ch", edge_ch, m_ech);
            chk("edge_dir", edge_dir, m_dir);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        if (edge_valid) n_edges++;
        check_all();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wait_cnt(input int ch, input int val, input string tag);
        int k;
        k = 0;
        while (m_cnt[ch] != val && k < 100) begin
            tick();
            k++;
        end
        chk(tag, (k < 100), 1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_clean"}, clean_out, 0);
        chk({tag, "_ev"}, edge_valid, 0);
        chk({tag, "_ech"}, edge_ch, 0);
        chk({tag, "_dir"}, edge_dir, 0);
        chk({tag, "_idx"}, scan_idx, 0);
    endtask

    initial begin
        reset = 1'b1; noisy_in = '0; threshold = 8'd3;
        enable = 1'b0; clear = 1'b0;
        model_reset();
        #2;
        check_zero("rst");
        @(posedge clk); @(posedge clk); #1;
        check_zero("rst_hold");
        reset = 1'b0;

        // Stable rise on channel 0, thr=3
        enable = 1'b1;
        noisy_in = 4'b0001;
        n_edges = 0;
        run(30);
        chk("r031_clean0", clean_out[0], 1'b1);
        chk("r031_edges", n_edges, 1);

        // Short pulse on channel 2 must be rejected
        n_edges = 0;
        noisy_in = 4'b0101;
        run(6);
        noisy_in = 4'b0001;
        run(20);
        chk("r032_clean2", clean_out[2], 1'b0);
        chk("r032_edges", n_edges, 0);

        // Zero threshold acts as one
        threshold = 8'd0;
        noisy_in = 4'b0011;
        run(2 + NCH + 1);
        chk("r033_clean1", clean_out[1], 1'b1);

        // Freeze mid-count on channel 3
        threshold = 8'd3;
        noisy_in = 4'b1011;
        wait_cnt(3, 2, "r034_reach");
        enable = 1'b0;
        run(20);
        chk("r034_frozen", clean_out[3], 1'b0);
        chk("r034_cnt", m_cnt[3], 2);
        enable = 1'b1;
        run(12);
        chk("r034_flip", clean_out[3], 1'b1);

        // Clear beats enable
        noisy_in = 4'b1010;
        wait_cnt(0, 2, "r035_reach");
        clear = 1'b1;
        tick();
        chk("r035_idx", scan_idx, 0);
        chk("r035_clean", clean_out, 4'b1011);
        clear = 1'b0;
        tick();
        chk("r035_idle", scan_idx, 0);
        run(16);
        chk("r035_flip", clean_out, 4'b1010);

        // Async reset mid-count
        noisy_in = 4'b1000;
        wait_cnt(1, 2, "r036_reach");
        #2;
        reset = 1'b1;
        #1;
        check_zero("r036");
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        n_edges = 0;
        run(6);
        chk("r036_noedge", n_edges, 0);
        run(20);
        chk("r036_flip", clean_out, 4'b1000);

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 15) == 0)
                noisy_in[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 49) == 0)
                threshold = 8'($urandom_range(0, 4));
            enable = ($urandom_range(0, 19) != 0);
            clear  = ($urandom_range(0, 63) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
